hier_node_dispatch: RTL and testbench
=====================================

// Module: hier_node_dispatch
// PURPOSE
//  Parametrised hierarchy tree node: accepts one request from its parent, dispatches it
//  to NUM_CHILDREN child ports (round-robin single target or broadcast), collects child
//  completion pulses, and returns one aggregated acknowledge upstream. Nodes chain into
//  arbitrary-depth/width trees: the parent-side ack feeds a higher node's child response.
// PARAMETERS
//  NUM_CHILDREN  5   number of child ports, >=1
//  DATA_W        32  request payload width
//  TIMEOUT_CYC   16  WAIT-state cycle limit before forced partial ack, >=1
// PORTS
//  clk          in   1             single clock, rising edge
//  rst_n        in   1             asynchronous active-low reset
//  mode         in   1             0 = round-robin single child, 1 = broadcast; sampled on up accept
//  up_valid     in   1             parent request valid
//  up_ready     out  1             node can accept request
//  up_data      in   DATA_W        request payload
//  dn_valid     out  NUM_CHILDREN  per-child request valid
//  dn_ready     in   NUM_CHILDREN  per-child ready
//  dn_data      out  DATA_W        registered payload, shared by all children
//  rsp_valid    in   NUM_CHILDREN  per-child one-cycle completion pulse
//  ack_valid    out  1             aggregated acknowledge valid
//  ack_ready    in   1             parent accepts acknowledge
//  ack_count    out  CNT_W         children that completed; CNT_W = $clog2(NUM_CHILDREN+1)
//  ack_timeout  out  1             ack issued due to timeout (partial)
//  busy         out  1             state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, dn_valid=0, dn_data=0, ack_valid=0, ack_count=0,
//   ack_timeout=0, internal masks/counter=0. up_ready=0 while rst_n low, 1 in IDLE after.
//  FSM IDLE->ISSUE->WAIT->ACK->IDLE; up_ready = (state==IDLE), combinational.
//  IDLE: on up_valid&up_ready register up_data into dn_data; expect_mask = all-ones
//   (mode=1) or onehot(rr_ptr) (mode=0); pending = expect_mask; done_mask=0 -> ISSUE.
//  ISSUE: dn_valid = pending; bit i clears on dn_valid[i]&dn_ready[i]. When pending
//   would be 0 after this cycle -> WAIT; timer cleared. dn_data stable until ACK exit.
//  rsp collection active in ISSUE and WAIT: done_mask |= rsp_valid & expect_mask.
//   Unexpected-child pulses ignored; repeat pulses from one child count once. Pulse
//   in the same cycle as that child's dn handshake is counted.
//  WAIT: timer increments each cycle. done_mask==expect_mask (incl. this cycle's pulses)
//   -> ACK, ack_timeout=0. Else timer==TIMEOUT_CYC-1 -> ACK, ack_timeout=1.
//  ACK: ack_valid=1, ack_count=popcount(done_mask), both held stable until ack_ready.
//   On ack_valid&ack_ready -> IDLE; ack_valid/ack_timeout cleared next cycle. In mode 0
//   rr_ptr advances on that handshake, wrapping NUM_CHILDREN-1 -> 0; mode 1 leaves it.
//   Pulses arriving in ACK are dropped.
//  Latency: request accept -> dn_valid high 1 cycle; last rsp pulse -> ack_valid 1 cycle.
//  mode changes while busy have no effect on the in-flight request.
//  Reset asserted mid-operation: immediate return to reset values; in-flight request lost.
// STRUCTURE
//  Package hier_node_pkg: typedef enum logic [1:0] {IDLE,ISSUE,WAIT,ACK} node_state_t;
//   function cnt_w(n) = $clog2(n+1); MODE_RR=1'b0 / MODE_BCAST=1'b1 constants.
//  One sub-module: hier_node_popcount #(N) (combinational, mask -> CNT_W count).
// TESTING (NUM_CHILDREN=5, TIMEOUT_CYC=16)
//  RR x6, all ready, each child pulses 2 cycles after handshake -> targets 0,1,2,3,4,0;
//   each ack_count=1, ack_timeout=0.
//  Broadcast, dn_ready staggered (child 3 ready 4 cycles late), all pulse -> dn_valid
//   5'b11111 shrinks bitwise; one ack, ack_count=5.
//  Broadcast, child 2 never pulses -> ack after 16 WAIT cycles, ack_count=4, ack_timeout=1.
//  RR target 1: child 4 pulses (ignored), child 1 pulses twice -> ack_count=1.
//  ack_ready held low 10 cycles -> ack_valid/ack_count stable, up_ready=0, rr_ptr unchanged
//   until handshake.
//  rst_n low during WAIT -> next cycle all outputs at reset values, up_ready=1 after release.

Source files
------------

// File: rtl/hier_node_pkg.sv
// Shared types and helpers for the hierarchy tree node: FSM encoding, dispatch
// mode constants and the width helpers used to size counters and pointers.
package hier_node_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } node_state_t;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_BCAST = 1'b1;

    // Bits needed to hold a count of 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Bits needed to index n items, never less than one.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hier_node_popcount.sv
// Combinational population count: number of set bits in an N-wide mask.
module hier_node_popcount
    import hier_node_pkg::*;
#(
    parameter int N = 5,
    localparam int CNT_W = cnt_w(N)
) (
    input  logic [N-1:0]     mask,
    output logic [CNT_W-1:0] count
);

    always_comb begin : popcount_sum
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + CNT_W'(mask[i]);
        end
    end

endmodule

// File: rtl/hier_node_dispatch.sv
// Hierarchy tree node: takes one parent request, dispatches it to one child
// (round-robin) or all children (broadcast), and returns one aggregated ack.
module hier_node_dispatch
    import hier_node_pkg::*;
#(
    parameter int NUM_CHILDREN = 5,
    parameter int DATA_W       = 32,
    parameter int TIMEOUT_CYC  = 16,
    localparam int CNT_W       = cnt_w(NUM_CHILDREN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode,
    input  logic                    up_valid,
    output logic                    up_ready,
    input  logic [DATA_W-1:0]       up_data,
    output logic [NUM_CHILDREN-1:0] dn_valid,
    input  logic [NUM_CHILDREN-1:0] dn_ready,
    output logic [DATA_W-1:0]       dn_data,
    input  logic [NUM_CHILDREN-1:0] rsp_valid,
    output logic                    ack_valid,
    input  logic                    ack_ready,
    output logic [CNT_W-1:0]        ack_count,
    output logic                    ack_timeout,
    output logic                    busy
);

    localparam int PTR_W = idx_w(NUM_CHILDREN);
    localparam int TMR_W = idx_w(TIMEOUT_CYC);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_CHILDREN - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    node_state_t             state;
    node_state_t             state_nxt;
    logic [PTR_W-1:0]        rr_ptr;
    logic                    mode_q;
    logic [NUM_CHILDREN-1:0] expect_mask;
    logic [NUM_CHILDREN-1:0] pending;
    logic [NUM_CHILDREN-1:0] done_mask;
    logic [TMR_W-1:0]        timer;

    logic                    accept;
    logic                    ack_hs;
    logic [NUM_CHILDREN-1:0] rr_onehot;
    logic [NUM_CHILDREN-1:0] pending_clr;
    logic [NUM_CHILDREN-1:0] done_upd;
    logic                    all_done;
    logic [CNT_W-1:0]        done_count;

    assign accept = up_valid && up_ready;
    assign ack_hs = ack_valid && ack_ready;

    // Collection folds in this cycle's pulses so a final pulse and the
    // decision to acknowledge land in the same cycle.
    always_comb begin : mask_logic
        rr_onehot = '0;
        for (int i = 0; i < NUM_CHILDREN; i++) begin
            rr_onehot[i] = (rr_ptr == PTR_W'(i));
        end
        pending_clr = pending & ~dn_ready;
        done_upd    = done_mask | (rsp_valid & expect_mask);
        all_done    = (done_upd == expect_mask);
    end

    hier_node_popcount #(
        .N(NUM_CHILDREN)
    ) u_popcount (
        .mask  (done_mask),
        .count (done_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin : next_state_logic
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (pending_clr == '0) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (all_done || (timer == TMR_LAST)) begin
                    state_nxt = ACK;
                end
            end
            ACK: begin
                if (ack_hs) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin : output_logic
        up_ready  = 1'b0;
        dn_valid  = '0;
        ack_valid = 1'b0;
        ack_count = '0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                up_ready = rst_n;
                busy     = 1'b0;
            end
            ISSUE:   dn_valid = pending;
            WAIT:    busy = 1'b1;
            ACK: begin
                ack_valid = 1'b1;
                ack_count = done_count;
            end
            default: busy = 1'b0;
        endcase
    end

    // The request's mode is latched at accept so later mode changes cannot
    // alter an in-flight dispatch or the round-robin advance.
    always_ff @(posedge clk or negedge rst_n) begin : datapath_regs
        if (!rst_n) begin
            rr_ptr      <= '0;
            mode_q      <= MODE_RR;
            dn_data     <= '0;
            expect_mask <= '0;
            pending     <= '0;
            done_mask   <= '0;
            timer       <= '0;
            ack_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dn_data     <= up_data;
                        mode_q      <= mode;
                        expect_mask <= (mode == MODE_BCAST) ? '1 : rr_onehot;
                        pending     <= (mode == MODE_BCAST) ? '1 : rr_onehot;
                        done_mask   <= '0;
                        timer       <= '0;
                    end
                end
                ISSUE: begin
                    pending   <= pending_clr;
                    done_mask <= done_upd;
                    timer     <= '0;
                end
                WAIT: begin
                    done_mask <= done_upd;
                    timer     <= timer + TMR_W'(1);
                    if (state_nxt == ACK) begin
                        ack_timeout <= !all_done;
                    end
                end
                ACK: begin
                    if (ack_hs) begin
                        ack_timeout <= 1'b0;
                        if (mode_q == MODE_RR) begin
                            rr_ptr <= (rr_ptr == PTR_LAST) ? '0 : rr_ptr + PTR_W'(1);
                        end
                    end
                end
                default: timer <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_hier_node_dispatch.sv
// Self-checking bench for hier_node_dispatch: directed scenarios plus random
// transactions, each predicted by a transaction-level model of the node.
module tb_hier_node_dispatch;
    import hier_node_pkg::*;

    localparam int NC = 5;
    localparam int DW = 32;
    localparam int TO = 16;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mode;
    logic          up_valid;
    logic          up_ready;
    logic [DW-1:0] up_data;
    logic [NC-1:0] dn_valid;
    logic [NC-1:0] dn_ready;
    logic [DW-1:0] dn_data;
    logic [NC-1:0] rsp_valid;
    logic          ack_valid;
    logic          ack_ready;
    logic [CW-1:0] ack_count;
    logic          ack_timeout;
    logic          busy;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    // Model state: round-robin pointer and per-child schedules for a transaction.
    // hs_cyc[i] is the cycle (0 = first dispatch cycle) child i raises ready;
    // bit c of pulse_sched[i] means child i pulses rsp_valid in cycle c.
    int          model_rr = 0;
    int          hs_cyc[NC];
    logic [63:0] pulse_sched[NC];

    always #5 clk = ~clk;

    hier_node_dispatch #(
        .NUM_CHILDREN (NC),
        .DATA_W       (DW),
        .TIMEOUT_CYC  (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode        (mode),
        .up_valid    (up_valid),
        .up_ready    (up_ready),
        .up_data     (up_data),
        .dn_valid    (dn_valid),
        .dn_ready    (dn_ready),
        .dn_data     (dn_data),
        .rsp_valid   (rsp_valid),
        .ack_valid   (ack_valid),
        .ack_ready   (ack_ready),
        .ack_count   (ack_count),
        .ack_timeout (ack_timeout),
        .busy        (busy)
    );

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Children among targets that have pulsed at least once in cycles 0..c.
    function automatic logic [NC-1:0] seen_by(input logic [NC-1:0] targets, input int c);
        logic [63:0] upto;
        logic [NC-1:0] s;
        upto = (c >= 63) ? '1 : ((64'd1 << (c + 1)) - 64'd1);
        s = '0;
        for (int i = 0; i < NC; i++) begin
            s[i] = targets[i] && ((pulse_sched[i] & upto) != 64'd0);
        end
        return s;
    endfunction

    task automatic clear_schedule();
        for (int i = 0; i < NC; i++) begin
            hs_cyc[i]      = 0;
            pulse_sched[i] = 64'd0;
        end
    endtask

    task automatic random_schedule();
        for (int i = 0; i < NC; i++) begin
            hs_cyc[i]      = int'($urandom_range(0, 4));
            pulse_sched[i] = 64'd0;
            if ($urandom_range(0, 7) != 0) begin
                pulse_sched[i][hs_cyc[i] + int'($urandom_range(0, 3))] = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) begin
                pulse_sched[i][int'($urandom_range(0, 9))] = 1'b1;
            end
        end
    endtask

    // Runs one full request/ack transaction against the current schedule.
    task automatic apply_stimulus(input logic txn_mode, input int ack_hold, input string name);
        logic [NC-1:0] targets;
        logic [NC-1:0] done_set;
        logic [NC-1:0] exp_dn;
        logic [DW-1:0] payload;
        int            issue_last;
        int            ack_c;
        logic          found;

        payload = DW'($urandom);
        targets = '0;
        if (txn_mode == MODE_BCAST) targets = '1;
        else targets[model_rr] = 1'b1;

        // Dispatch ends with the latest target handshake; waiting then lasts
        // until every target has pulsed or TO wait cycles have elapsed.
        issue_last = 0;
        for (int i = 0; i < NC; i++) begin
            if (targets[i] && hs_cyc[i] > issue_last) issue_last = hs_cyc[i];
        end
        ack_c = issue_last + TO;
        found = 1'b0;
        for (int c = issue_last + 1; c <= issue_last + TO; c++) begin
            if (!found && seen_by(targets, c) == targets) begin
                ack_c = c;
                found = 1'b1;
            end
        end
        done_set = seen_by(targets, ack_c);

        @(negedge clk);
        mode     = txn_mode;
        up_data  = payload;
        up_valid = 1'b1;
        check_output({name, " up_ready idle"}, 64'(up_ready), 64'd1);
        check_output({name, " busy idle"}, 64'(busy), 64'd0);

        for (int c = 0; c <= ack_c; c++) begin
            @(negedge clk);
            up_valid = 1'b0;
            up_data  = DW'($urandom);
            mode     = 1'($urandom);
            for (int i = 0; i < NC; i++) begin
                dn_ready[i]  = targets[i] ? (c >= hs_cyc[i]) : 1'($urandom);
                rsp_valid[i] = pulse_sched[i][c];
                exp_dn[i]    = targets[i] && (c <= hs_cyc[i]);
            end
            check_output({name, " dn_valid"}, 64'(dn_valid), 64'(exp_dn));
            check_output({name, " dn_data"}, 64'(dn_data), 64'(payload));
            check_output({name, " ack_valid early"}, 64'(ack_valid), 64'd0);
            check_output({name, " up_ready busy"}, 64'(up_ready), 64'd0);
        end

        for (int h = 0; h <= ack_hold; h++) begin
            @(negedge clk);
            ack_ready = (h == ack_hold);
            rsp_valid = NC'($urandom);
            dn_ready  = NC'($urandom);
            check_output({name, " ack_valid"}, 64'(ack_valid), 64'd1);
            check_output({name, " ack_count"}, 64'(ack_count), 64'($countones(done_set)));
            check_output({name, " ack_timeout"}, 64'(ack_timeout), 64'(done_set != targets));
            check_output({name, " up_ready in ack"}, 64'(up_ready), 64'd0);
            check_output({name, " dn_valid in ack"}, 64'(dn_valid), 64'd0);
        end

        @(negedge clk);
        ack_ready = 1'b0;
        rsp_valid = '0;
        check_output({name, " ack_valid cleared"}, 64'(ack_valid), 64'd0);
        check_output({name, " ack_timeout cleared"}, 64'(ack_timeout), 64'd0);
        check_output({name, " up_ready after ack"}, 64'(up_ready), 64'd1);
        if (txn_mode == MODE_RR) model_rr = (model_rr + 1) % NC;
    endtask

    task automatic check_reset_values(input string name);
        check_output({name, " up_ready"}, 64'(up_ready), 64'd0);
        check_output({name, " dn_valid"}, 64'(dn_valid), 64'd0);
        check_output({name, " dn_data"}, 64'(dn_data), 64'd0);
        check_output({name, " ack_valid"}, 64'(ack_valid), 64'd0);
        check_output({name, " ack_count"}, 64'(ack_count), 64'd0);
        check_output({name, " ack_timeout"}, 64'(ack_timeout), 64'd0);
        check_output({name, " busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        mode      = MODE_RR;
        up_valid  = 1'b0;
        up_data   = '0;
        dn_ready  = '0;
        rsp_valid = '0;
        ack_ready = 1'b0;

        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_output("post-reset up_ready", 64'(up_ready), 64'd1);

        // Round-robin over all children and wrap back to child 0.
        for (int k = 0; k < 6; k++) begin
            clear_schedule();
            pulse_sched[model_rr] = 64'd1 << 2;
            apply_stimulus(MODE_RR, 0, $sformatf("rr%0d", k));
        end

        // Child 1 pulses twice (second with its handshake), child 4 unexpected.
        clear_schedule();
        hs_cyc[1]      = 3;
        pulse_sched[1] = (64'd1 << 2) | (64'd1 << 3);
        pulse_sched[4] = 64'd1 << 2;
        apply_stimulus(MODE_RR, 0, "rr_dup");

        // Broadcast with child 3 ready four cycles late.
        clear_schedule();
        hs_cyc[3] = 4;
        for (int i = 0; i < NC; i++) pulse_sched[i] = 64'd1 << (hs_cyc[i] + 2);
        apply_stimulus(MODE_BCAST, 0, "bcast_stagger");

        // Broadcast where child 2 never answers: partial ack by timeout.
        clear_schedule();
        for (int i = 0; i < NC; i++) pulse_sched[i] = (i == 2) ? 64'd0 : 64'd1 << 2;
        apply_stimulus(MODE_BCAST, 0, "bcast_timeout");

        // Parent holds off the ack for ten cycles.
        clear_schedule();
        pulse_sched[model_rr] = 64'd1 << 1;
        apply_stimulus(MODE_RR, 10, "ack_hold");

        // Reset while waiting for responses discards the request.
        clear_schedule();
        @(negedge clk);
        mode     = MODE_BCAST;
        up_data  = DW'($urandom);
        up_valid = 1'b1;
        @(negedge clk);
        up_valid = 1'b0;
        dn_ready = '1;
        repeat (3) @(negedge clk);
        check_output("wait busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_values("mid reset");
        rst_n    = 1'b1;
        dn_ready = '0;
        model_rr = 0;
        @(negedge clk);
        check_output("mid reset up_ready", 64'(up_ready), 64'd1);

        clear_schedule();
        pulse_sched[model_rr] = 64'd1 << 2;
        apply_stimulus(MODE_RR, 0, "rr_after_reset");

        for (int k = 0; k < 20; k++) begin
            random_schedule();
            apply_stimulus(1'($urandom), int'($urandom_range(0, 3)), $sformatf("rand%0d", k));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
